// File: rtl/node_layer_sequencer.sv
// node_layer_sequencer: runs one shared MAC datapath over NUM_NODES nodes.
// Each node gets a clear cycle, IMAGE_SIZE accumulate cycles (stallable by
// data_rdy), then a capture cycle that writes the node result to the buffer.
module node_layer_sequencer #(
    parameter int IMAGE_SIZE = 64,
    parameter int NUM_NODES  = 10,
    localparam int NW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          abort,
    input  logic          data_rdy,
    output logic          busy,
    output logic          done,
    output logic          acc_clr,
    output logic          acc_hold,
    output logic [6:0]    cnt_val,
    output logic [NW-1:0] node_sel,
    output logic          wr_en,
    output logic [NW-1:0] wr_addr
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ACCUM, S_CAPTURE, S_DONE
    } state_t;

    localparam logic [6:0]    LAST_CNT  = 7'(IMAGE_SIZE - 1);
    localparam logic [NW-1:0] LAST_NODE = NW'(NUM_NODES - 1);
    localparam logic [NW-1:0] ONE_NODE  = NW'(1);

    state_t state, state_nxt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; abort beats every other transition, including go in IDLE
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (go) state_nxt = S_CLEAR;
                S_CLEAR:   state_nxt = S_ACCUM;
                S_ACCUM:   if (data_rdy && cnt_val == LAST_CNT) state_nxt = S_CAPTURE;
                S_CAPTURE: state_nxt = (node_sel == LAST_NODE) ? S_DONE : S_CLEAR;
                S_DONE:    state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // Term counter and node index; the counter saturates at the last term so
    // it shows IMAGE_SIZE-1 through CAPTURE and is zero again by CLEAR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_val  <= '0;
            node_sel <= '0;
        end else if (abort) begin
            cnt_val  <= '0;
            node_sel <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt_val  <= '0;
                    node_sel <= '0;
                end
                S_ACCUM: begin
                    if (data_rdy && cnt_val != LAST_CNT) cnt_val <= cnt_val + 7'd1;
                end
                S_CAPTURE: begin
                    cnt_val <= '0;
                    if (node_sel != LAST_NODE) node_sel <= node_sel + ONE_NODE;
                end
                S_DONE: begin
                    cnt_val  <= '0;
                    node_sel <= '0;
                end
                default: ;
            endcase
        end
    end

    // Moore outputs; abort masks the write and done pulses in its own cycle
    always_comb begin
        busy     = (state != S_IDLE);
        acc_clr  = (state == S_CLEAR);
        acc_hold = !((state == S_ACCUM) && data_rdy && !abort);
        wr_en    = (state == S_CAPTURE) && !abort;
        wr_addr  = node_sel;
        done     = (state == S_DONE) && !abort;
    end

endmodule

// File: tb/tb_node_layer_sequencer.sv
// Bench for node_layer_sequencer with IMAGE_SIZE=4, NUM_NODES=3.
// Expected writes and done pulses (with their cycle numbers) are queued when
// a layer is launched and popped by a monitor as the DUT produces them.
module tb_node_layer_sequencer;

    localparam int IS = 4;
    localparam int NN = 3;

    logic       clk = 1'b0;
    logic       rst, go, abort, data_rdy;
    logic       busy, done, acc_clr, acc_hold, wr_en;
    logic [6:0] cnt_val;
    logic [1:0] node_sel, wr_addr;

    node_layer_sequencer #(.IMAGE_SIZE(IS), .NUM_NODES(NN)) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort), .data_rdy(data_rdy),
        .busy(busy), .done(done), .acc_clr(acc_clr), .acc_hold(acc_hold),
        .cnt_val(cnt_val), .node_sel(node_sel), .wr_en(wr_en), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct { int addr; int at; } wr_exp_t;
    wr_exp_t wr_q[$];
    int      done_q[$];

    // Monitor: per-cycle invariants plus scoreboard pops for wr_en / done
    always @(negedge clk) begin
        wr_exp_t e;
        int      d;
        if (!rst) begin
            total++;
            if (acc_clr && wr_en) begin
                bad++;
                $display("FAIL clr_wr_overlap cyc=%0d: acc_clr=%b wr_en=%b, required not both high", cyc, acc_clr, wr_en);
            end
            total++;
            if (cnt_val > 7'd3) begin
                bad++;
                $display("FAIL cnt_range cyc=%0d: cnt_val=%0d, required <= 3", cyc, cnt_val);
            end
            if (wr_en) begin
                total++;
                if (wr_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_wr cyc=%0d: wr_addr=%0d, required no write", cyc, wr_addr);
                end else begin
                    e = wr_q.pop_front();
                    if (wr_addr !== 2'(e.addr) || cyc != e.at) begin
                        bad++;
                        $display("FAIL wr_check: got addr=%0d at cyc=%0d, required addr=%0d at cyc=%0d", wr_addr, cyc, e.addr, e.at);
                    end
                end
            end
            if (done) begin
                total++;
                if (done_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done cyc=%0d: done=1, required 0", cyc);
                end else begin
                    d = done_q.pop_front();
                    if (cyc != d) begin
                        bad++;
                        $display("FAIL done_cycle: got cyc=%0d, required cyc=%0d", cyc, d);
                    end
                end
            end
        end
    end

    // Pulse go for one cycle; returns the cycle number in which go was high
    task automatic start_layer(output int t0);
        @(posedge clk); #1;
        go = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic push_layer(input int t0, input int a0, input int a1, input int a2, input int dn);
        wr_q.push_back('{addr: 0, at: t0 + a0});
        wr_q.push_back('{addr: 1, at: t0 + a1});
        wr_q.push_back('{addr: 2, at: t0 + a2});
        done_q.push_back(t0 + dn);
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; abort = 1'b0; data_rdy = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)     begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        total++; if (acc_clr !== 1'b0)  begin bad++; $display("FAIL rst_acc_clr: got %b want 0", acc_clr); end
        total++; if (acc_hold !== 1'b1) begin bad++; $display("FAIL rst_acc_hold: got %b want 1", acc_hold); end
        total++; if (cnt_val !== 7'd0)  begin bad++; $display("FAIL rst_cnt: got %0d want 0", cnt_val); end
        total++; if (node_sel !== 2'd0) begin bad++; $display("FAIL rst_node_sel: got %0d want 0", node_sel); end
        total++; if (wr_en !== 1'b0)    begin bad++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
        total++; if (wr_addr !== 2'd0)  begin bad++; $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_rst: busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int t0;
        start_layer(t0);
        push_layer(t0, 6, 12, 18, 19);
        for (int c = t0 + 1; c <= t0 + 21; c++) begin
            @(negedge clk);
            if (c == t0 + 1) begin
                total++;
                if (acc_clr !== 1'b1 || cnt_val !== 7'd0 || node_sel !== 2'd0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL basic_clear: acc_clr=%b cnt=%0d node=%0d busy=%b, want 1/0/0/1", acc_clr, cnt_val, node_sel, busy);
                end
            end
            if (c >= t0 + 2 && c <= t0 + 5) begin
                total++;
                if (cnt_val !== 7'(c - t0 - 2) || acc_hold !== 1'b0) begin
                    bad++;
                    $display("FAIL basic_accum cyc=%0d: cnt=%0d hold=%b, want cnt=%0d hold=0", c - t0, cnt_val, acc_hold, c - t0 - 2);
                end
            end
            if (c == t0 + 20) begin
                total++;
                if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy); end
            end
            @(posedge clk); #1;
        end
        total++;
        if (wr_q.size() != 0 || done_q.size() != 0) begin
            bad++;
            $display("FAIL basic_drain: pending wr=%0d done=%0d, want 0/0", wr_q.size(), done_q.size());
        end
    endtask

    task automatic test_stall();
        int t0;
        start_layer(t0);
        push_layer(t0, 6, 14, 20, 21);
        for (int c = t0 + 1; c <= t0 + 23; c++) begin
            data_rdy = !(c == t0 + 10 || c == t0 + 11);
            @(negedge clk);
            if (c == t0 + 10 || c == t0 + 11) begin
                total++;
                if (cnt_val !== 7'd2 || acc_hold !== 1'b1 || node_sel !== 2'd1) begin
                    bad++;
                    $display("FAIL stall_hold cyc=%0d: cnt=%0d hold=%b node=%0d, want 2/1/1", c - t0, cnt_val, acc_hold, node_sel);
                end
            end
            if (c == t0 + 12) begin
                total++;
                if (cnt_val !== 7'd2 || acc_hold !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_resume: cnt=%0d hold=%b, want 2/0", cnt_val, acc_hold);
                end
            end
            if (c == t0 + 22) begin
                total++;
                if (busy !== 1'b0) begin bad++; $display("FAIL stall_busy_end: got %b want 0", busy); end
            end
            @(posedge clk); #1;
        end
        data_rdy = 1'b1;
        total++;
        if (wr_q.size() != 0 || done_q.size() != 0) begin
            bad++;
            $display("FAIL stall_drain: pending wr=%0d done=%0d, want 0/0", wr_q.size(), done_q.size());
        end
    endtask

    task automatic test_abort();
        int t0;
        start_layer(t0);
        wr_q.push_back('{addr: 0, at: t0 + 6});
        wr_q.push_back('{addr: 1, at: t0 + 12});
        for (int c = t0 + 1; c <= t0 + 24; c++) begin
            abort = (c == t0 + 15);
            @(negedge clk);
            if (c == t0 + 15) begin
                total++;
                if (cnt_val !== 7'd1 || node_sel !== 2'd2) begin
                    bad++;
                    $display("FAIL abort_point: cnt=%0d node=%0d, want 1/2", cnt_val, node_sel);
                end
            end
            if (c == t0 + 16) begin
                total++;
                if (busy !== 1'b0 || cnt_val !== 7'd0 || node_sel !== 2'd0) begin
                    bad++;
                    $display("FAIL abort_idle: busy=%b cnt=%0d node=%0d, want 0/0/0", busy, cnt_val, node_sel);
                end
            end
            @(posedge clk); #1;
        end
        abort = 1'b0;
        total++;
        if (wr_q.size() != 0) begin bad++; $display("FAIL abort_drain: pending wr=%0d want 0", wr_q.size()); end
        // restart after abort must begin again at node 0
        start_layer(t0);
        push_layer(t0, 6, 12, 18, 19);
        for (int c = t0 + 1; c <= t0 + 21; c++) begin
            @(negedge clk);
            if (c == t0 + 1) begin
                total++;
                if (acc_clr !== 1'b1 || node_sel !== 2'd0) begin
                    bad++;
                    $display("FAIL abort_restart: acc_clr=%b node=%0d, want 1/0", acc_clr, node_sel);
                end
            end
            @(posedge clk); #1;
        end
        total++;
        if (wr_q.size() != 0 || done_q.size() != 0) begin
            bad++;
            $display("FAIL restart_drain: pending wr=%0d done=%0d, want 0/0", wr_q.size(), done_q.size());
        end
    endtask

    task automatic test_go_busy();
        int t0;
        start_layer(t0);
        push_layer(t0, 6, 12, 18, 19);
        for (int c = t0 + 1; c <= t0 + 30; c++) begin
            go = (c == t0 + 3);
            @(negedge clk);
            if (c == t0 + 20 || c == t0 + 27) begin
                total++;
                if (busy !== 1'b0) begin bad++; $display("FAIL go_busy_idle cyc=%0d: busy=%b want 0", c - t0, busy); end
            end
            @(posedge clk); #1;
        end
        go = 1'b0;
        total++;
        if (wr_q.size() != 0 || done_q.size() != 0) begin
            bad++;
            $display("FAIL go_busy_drain: pending wr=%0d done=%0d, want 0/0", wr_q.size(), done_q.size());
        end
    endtask

    task automatic test_rst_mid();
        int t0;
        start_layer(t0);
        wr_q.push_back('{addr: 0, at: t0 + 6});
        for (int c = t0 + 1; c < t0 + 12; c++) begin
            @(posedge clk); #1;
        end
        // now in node 1 CAPTURE
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 2'd1) begin
            bad++;
            $display("FAIL rst_mid_pre: wr_en=%b wr_addr=%0d, want 1/1", wr_en, wr_addr);
        end
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || acc_clr !== 1'b0 || acc_hold !== 1'b1 ||
            cnt_val !== 7'd0 || node_sel !== 2'd0 || wr_en !== 1'b0 || wr_addr !== 2'd0) begin
            bad++;
            $display("FAIL rst_mid_async: busy=%b done=%b clr=%b hold=%b cnt=%0d node=%0d wr=%b addr=%0d, want 0/0/0/1/0/0/0/0",
                     busy, done, acc_clr, acc_hold, cnt_val, node_sel, wr_en, wr_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (25) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || wr_q.size() != 0 || done_q.size() != 0) begin
            bad++;
            $display("FAIL rst_mid_after: busy=%b pending wr=%0d done=%0d, want 0/0/0", busy, wr_q.size(), done_q.size());
        end
    endtask

    task automatic test_abort_go_idle();
        @(posedge clk); #1;
        go = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        go = 1'b0; abort = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || acc_clr !== 1'b0) begin
            bad++;
            $display("FAIL abort_go_idle: busy=%b acc_clr=%b, want 0/0", busy, acc_clr);
        end
        repeat (8) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_abort();
        test_go_busy();
        test_rst_mid();
        test_abort_go_idle();
        test_basic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/node_layer_sequencer.md
NODE_LAYER_SEQUENCER -- requirements
Module: node_layer_sequencer

Interface
REQ-001 The block SHALL have parameter IMAGE_SIZE, default 64, giving the number of multiply-accumulate terms per node.
REQ-002 The block SHALL have parameter NUM_NODES, default 10, giving the number of nodes time-multiplexed onto one shared node datapath.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 go  input  1  request to evaluate one full layer; sampled only in IDLE.
REQ-007 abort  input  1  synchronous cancel of a layer in progress.
REQ-008 data_rdy  input  1  current coefficient/data term valid; low stalls accumulation.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when the layer completes.
REQ-011 acc_clr  output  1  clears the shared accumulator.
REQ-012 acc_hold  output  1  accumulator keeps its value this cycle (1 = hold, 0 = add term).
REQ-013 cnt_val  output  7  term index into coefficient/data arrays.
REQ-014 node_sel  output  $clog2(NUM_NODES)  selects the coefficient bank of the node being evaluated.
REQ-015 wr_en  output  1  captures the node result into the layer output buffer.
REQ-016 wr_addr  output  $clog2(NUM_NODES)  output buffer index for wr_en.

Function
REQ-017 The FSM SHALL have states IDLE, CLEAR, ACCUM, CAPTURE, DONE.
REQ-018 IDLE: acc_hold=1, acc_clr=0, wr_en=0; go=1 -> CLEAR with node_sel=0; go=0 -> stay.
REQ-019 CLEAR: lasts exactly 1 cycle; acc_clr=1, acc_hold=1, cnt_val=0; -> ACCUM.
REQ-020 ACCUM, data_rdy=1: acc_hold=0; cnt_val increments by 1 each cycle.
REQ-021 ACCUM, data_rdy=0: acc_hold=1; cnt_val and state held (stall); no term is lost or repeated.
REQ-022 ACCUM: when cnt_val=IMAGE_SIZE-1 and data_rdy=1 -> CAPTURE; cnt_val SHALL never exceed IMAGE_SIZE-1.
REQ-023 CAPTURE: lasts exactly 1 cycle; acc_hold=1, wr_en=1, wr_addr=node_sel.
REQ-024 CAPTURE: if node_sel=NUM_NODES-1 -> DONE; otherwise node_sel+1 and -> CLEAR.
REQ-025 DONE: done=1 for exactly 1 cycle; -> IDLE; node_sel resets to 0.
REQ-026 Latency with no stalls: NUM_NODES*(IMAGE_SIZE+2) cycles from the go-sampling edge to the DONE state; done is high in cycle NUM_NODES*(IMAGE_SIZE+2)+1.
REQ-027 Each stalled cycle SHALL add exactly one cycle to latency.
REQ-028 go while busy=1 SHALL be ignored (not queued).
REQ-029 abort=1 in any non-IDLE state -> IDLE on the next edge; no wr_en or done in that cycle; node_sel and cnt_val -> 0.
REQ-030 abort has priority over data_rdy and over every state transition; abort and go together in IDLE -> stay in IDLE.
REQ-031 acc_clr and wr_en SHALL never be high in the same cycle; wr_en SHALL pulse exactly once per node per completed layer.

Reset
REQ-032 While rst=1: state=IDLE, busy=0, done=0, acc_clr=0, acc_hold=1, cnt_val=0, node_sel=0, wr_en=0, wr_addr=0.
REQ-033 rst asserted mid-layer SHALL force the reset values immediately (asynchronously), with no further wr_en or done.
REQ-034 After rst deasserts, the block SHALL wait in IDLE for go.

Verification (IMAGE_SIZE=4, NUM_NODES=3)
REQ-035 go pulse, data_rdy=1 -> CLEAR at cycle 1; cnt_val 0,1,2,3 in cycles 2-5; wr_en with wr_addr=0 in cycle 6; wr_addr 1 and 2 in cycles 12 and 18; done in cycle 19; busy=0 in cycle 20.
REQ-036 Same as REQ-035 with data_rdy=0 for 2 cycles at cnt_val=2 of node 1 -> cnt_val holds 2 with acc_hold=1; done moves to cycle 21.
REQ-037 abort at cnt_val=1 of node 2 -> IDLE next cycle; no wr_en for node 2; no done; a new go restarts at node_sel=0.
REQ-038 go re-pulsed during ACCUM -> no effect; exactly 3 wr_en and 1 done.
REQ-039 rst pulsed during CAPTURE of node 1 -> all outputs immediately at reset values; no done follows.
REQ-040 Check in every cycle: acc_clr and wr_en never both high; cnt_val <= 3.
